// File: rtl/geofence_pkg.sv
// Shared widths and types for the geofence datapath.
package geofence_pkg;

  localparam int unsigned CW = 11;         // signed coordinate width
  localparam int unsigned DW = CW + 1;     // coordinate difference width
  localparam int unsigned PW = 2 * CW + 2; // product width
  localparam int unsigned RW = 2 * CW + 3; // cross product width

  typedef struct packed {
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
  } point_t;

endpackage

// File: rtl/xprod_pipe.sv
// Fixed-latency signed cross product (a-o) x (b-o) with a valid bit and requester tag.
// With LAT>=2 the products are registered in the first stage, the subtract feeds the
// second stage and any further stages are plain delay.
module xprod_pipe #(
  parameter int unsigned CW  = geofence_pkg::CW,
  parameter int unsigned LAT = 2,
  parameter int unsigned TW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [TW-1:0]         in_tag,
  input  logic signed [CW-1:0]  ax,
  input  logic signed [CW-1:0]  ay,
  input  logic signed [CW-1:0]  bx,
  input  logic signed [CW-1:0]  by,
  input  logic signed [CW-1:0]  ox,
  input  logic signed [CW-1:0]  oy,
  output logic                  out_valid,
  output logic [TW-1:0]         out_tag,
  output logic signed [2*CW+2:0] out_data
);
  import geofence_pkg::*;

  localparam int unsigned DIF_W = CW + 1;
  localparam int unsigned PRD_W = 2 * CW + 2;
  localparam int unsigned RES_W = 2 * CW + 3;

  logic signed [DIF_W-1:0] dax_c, day_c, dbx_c, dby_c;
  logic signed [PRD_W-1:0] prod_a_c, prod_b_c;
  logic [LAT-1:0]          vld_q, vld_d;
  logic [TW-1:0]           tag_q [LAT];
  logic [TW-1:0]           tag_d [LAT];

  // Sign-extended differences and full-width products; none of these can overflow.
  always_comb begin
    dax_c    = DIF_W'(ax) - DIF_W'(ox);
    day_c    = DIF_W'(ay) - DIF_W'(oy);
    dbx_c    = DIF_W'(bx) - DIF_W'(ox);
    dby_c    = DIF_W'(by) - DIF_W'(oy);
    prod_a_c = PRD_W'(dax_c) * PRD_W'(dby_c);
    prod_b_c = PRD_W'(day_c) * PRD_W'(dbx_c);
  end

  // Valid/tag shift; a tag stage only loads when a valid op enters it.
  always_comb begin
    vld_d[0] = in_valid;
    tag_d[0] = in_valid ? in_tag : tag_q[0];
    for (int k = 1; k < int'(LAT); k++) begin
      vld_d[k] = vld_q[k-1];
      tag_d[k] = vld_q[k-1] ? tag_q[k-1] : tag_q[k];
    end
  end

  // Valid/tag registers; reset discards every op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < int'(LAT); k++) tag_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < int'(LAT); k++) tag_q[k] <= tag_d[k];
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_tag   = tag_q[LAT-1];

  if (LAT == 1) begin : g_lat1
    logic signed [RES_W-1:0] res_q, res_d;

    // Single stage: whole result registered, held while idle.
    always_comb begin
      res_d = res_q;
      if (in_valid) res_d = RES_W'(prod_a_c) - RES_W'(prod_b_c);
    end

    // Result register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) res_q <= '0;
      else       res_q <= res_d;
    end

    assign out_data = res_q;
  end else begin : g_latn
    logic signed [PRD_W-1:0] pa_q, pa_d, pb_q, pb_d;
    logic signed [RES_W-1:0] res_q [LAT-1];
    logic signed [RES_W-1:0] res_d [LAT-1];

    // Products in stage 0, subtract into stage 1, delay beyond; each stage holds while idle.
    always_comb begin
      pa_d     = in_valid ? prod_a_c : pa_q;
      pb_d     = in_valid ? prod_b_c : pb_q;
      res_d[0] = vld_q[0] ? (RES_W'(pa_q) - RES_W'(pb_q)) : res_q[0];
      for (int j = 1; j < int'(LAT) - 1; j++) begin
        res_d[j] = vld_q[j] ? res_q[j-1] : res_q[j];
      end
    end

    // Data stage registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pa_q <= '0;
        pb_q <= '0;
        for (int j = 0; j < int'(LAT) - 1; j++) res_q[j] <= '0;
      end else begin
        pa_q <= pa_d;
        pb_q <= pb_d;
        for (int j = 0; j < int'(LAT) - 1; j++) res_q[j] <= res_d[j];
      end
    end

    assign out_data = res_q[LAT-2];
  end

endmodule

// File: rtl/cross_product_arbiter.sv
// Round-robin sharing of one pipelined cross-product unit among N_REQ requesters.
module cross_product_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned CW    = geofence_pkg::CW,
  parameter int unsigned LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*CW-1:0]   req_ax,
  input  logic [N_REQ*CW-1:0]   req_ay,
  input  logic [N_REQ*CW-1:0]   req_bx,
  input  logic [N_REQ*CW-1:0]   req_by,
  input  logic [N_REQ*CW-1:0]   req_ox,
  input  logic [N_REQ*CW-1:0]   req_oy,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [2*CW+2:0]       rsp_data,
  output logic [N_REQ-1:0]      inflight
);
  import geofence_pkg::*;

  localparam int unsigned TW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LAT + 1);

  logic [TW-1:0]          rr_q, rr_d;
  logic [TW-1:0]          gidx_c, idx_c;
  logic                   accept_c;
  logic signed [CW-1:0]   ax_c, ay_c, bx_c, by_c, ox_c, oy_c;
  logic                   pipe_valid;
  logic [TW-1:0]          pipe_tag;
  logic signed [2*CW+2:0] pipe_data;
  logic [CNT_W-1:0]       cnt_q [N_REQ];
  logic [CNT_W-1:0]       cnt_d [N_REQ];

  // Grant the first valid requester found searching upward from rr, wrapping.
  always_comb begin
    req_ready = '0;
    gidx_c    = '0;
    idx_c     = '0;
    accept_c  = 1'b0;
    if (!reset) begin
      for (int off = 0; off < int'(N_REQ); off++) begin
        idx_c = TW'((int'(rr_q) + off) % int'(N_REQ));
        if (!accept_c && req_valid[idx_c]) begin
          req_ready[idx_c] = 1'b1;
          gidx_c           = idx_c;
          accept_c         = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the winner on a handshake, holds otherwise.
  always_comb begin
    rr_d = rr_q;
    if (accept_c) begin
      if (int'(gidx_c) == int'(N_REQ) - 1) rr_d = '0;
      else                                 rr_d = gidx_c + TW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  // Operand mux selecting the granted requester's lane.
  always_comb begin
    ax_c = '0; ay_c = '0; bx_c = '0; by_c = '0; ox_c = '0; oy_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gidx_c == TW'(i)) begin
        ax_c = req_ax[i*CW +: CW];
        ay_c = req_ay[i*CW +: CW];
        bx_c = req_bx[i*CW +: CW];
        by_c = req_by[i*CW +: CW];
        ox_c = req_ox[i*CW +: CW];
        oy_c = req_oy[i*CW +: CW];
      end
    end
  end

  xprod_pipe #(.CW(CW), .LAT(LAT), .TW(TW)) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept_c),
    .in_tag   (gidx_c),
    .ax       (ax_c),
    .ay       (ay_c),
    .bx       (bx_c),
    .by       (by_c),
    .ox       (ox_c),
    .oy       (oy_c),
    .out_valid(pipe_valid),
    .out_tag  (pipe_tag),
    .out_data (pipe_data)
  );

  // Tag decode of the registered pipe output into one-hot response valid.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      rsp_valid[i] = pipe_valid && (pipe_tag == TW'(i));
    end
  end

  assign rsp_data = pipe_data;

  // Per-requester outstanding count: +1 on accept, -1 on response, both cancel.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept_c && (gidx_c == TW'(i)) && !rsp_valid[i])       cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!(accept_c && (gidx_c == TW'(i))) && rsp_valid[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  // Outstanding counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < int'(N_REQ); i++) cnt_q[i] <= '0;
    else       for (int i = 0; i < int'(N_REQ); i++) cnt_q[i] <= cnt_d[i];
  end

  // Inflight flags from the counters.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) inflight[i] = (cnt_q[i] != '0);
  end

endmodule

// File: tb/tb_cross_product_arbiter.sv
// Randomized and directed bench for cross_product_arbiter against a transaction-level model.
module tb_cross_product_arbiter;
  localparam int N   = 2;
  localparam int CW  = 11;
  localparam int LAT = 2;
  localparam int RW  = 2 * CW + 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, inflight;
  logic [N*CW-1:0] req_ax, req_ay, req_bx, req_by, req_ox, req_oy;
  logic [RW-1:0]   rsp_data;

  cross_product_arbiter #(.N_REQ(N), .CW(CW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ax(req_ax), .req_ay(req_ay), .req_bx(req_bx),
    .req_by(req_by), .req_ox(req_ox), .req_oy(req_oy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int tag; longint res; } op_t;

  int     n_pass, n_total;
  int     m_rr, last_g, cyc, r1_seen;
  int     m_cnt [N];
  longint last_data;
  op_t    q [$];
  bit     v_valid [N];
  int     v_ax [N], v_ay [N], v_bx [N], v_by [N], v_ox [N], v_oy [N];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
  endtask

  function automatic longint xp(input int i);
    return longint'(v_ax[i] - v_ox[i]) * longint'(v_by[i] - v_oy[i])
         - longint'(v_ay[i] - v_oy[i]) * longint'(v_bx[i] - v_ox[i]);
  endfunction

  function automatic int model_grant();
    for (int off = 0; off < N; off++) begin
      if (v_valid[(m_rr + off) % N]) return (m_rr + off) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = v_valid[i];
      req_ax[i*CW +: CW]   = CW'(v_ax[i]);
      req_ay[i*CW +: CW]   = CW'(v_ay[i]);
      req_bx[i*CW +: CW]   = CW'(v_bx[i]);
      req_by[i*CW +: CW]   = CW'(v_by[i]);
      req_ox[i*CW +: CW]   = CW'(v_ox[i]);
      req_oy[i*CW +: CW]   = CW'(v_oy[i]);
    end
  endtask

  task automatic set_op(input int i, input int ax, input int ay, input int bx,
                        input int by, input int ox, input int oy);
    v_valid[i] = 1'b1;
    v_ax[i] = ax; v_ay[i] = ay; v_bx[i] = bx; v_by[i] = by; v_ox[i] = ox; v_oy[i] = oy;
  endtask

  function automatic int rc();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic rand_op(input int i);
    set_op(i, rc(), rc(), rc(), rc(), rc(), rc());
  endtask

  // One clock cycle: check DUT against the model, then advance the model past the edge.
  task automatic step();
    int     g, exp_rv, exp_if;
    bit     due;
    longint exp_data;
    drive();
    #1;
    g = model_grant();
    check_eq("ready", longint'(req_ready), (g >= 0) ? longint'(1 << g) : 64'sd0);
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    due      = (q.size() > 0) && (q[0].due == cyc);
    exp_rv   = due ? (1 << q[0].tag) : 0;
    exp_data = due ? q[0].res : last_data;
    check_eq("rsp_valid", longint'(rsp_valid), longint'(exp_rv));
    check_eq("rsp_data", longint'($signed(rsp_data)), exp_data);
    exp_if = 0;
    for (int i = 0; i < N; i++) if (m_cnt[i] > 0) exp_if |= (1 << i);
    check_eq("inflight", longint'(inflight), longint'(exp_if));
    if (rsp_valid[1]) r1_seen++;
    if (due) begin
      m_cnt[q[0].tag]--;
      last_data = q[0].res;
      void'(q.pop_front());
    end
    if (g >= 0) begin
      q.push_back('{due: cyc + LAT, tag: g, res: xp(g)});
      m_cnt[g]++;
      m_rr = (g + 1) % N;
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Assert reset (asynchronously, mid-cycle), check the cleared state, then release.
  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) v_valid[i] = 1'b1;
    drive();
    #1;
    check_eq("rst_ready", longint'(req_ready), 0);
    check_eq("rst_rsp_valid", longint'(rsp_valid), 0);
    check_eq("rst_inflight", longint'(inflight), 0);
    q.delete();
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; v_valid[i] = 1'b0; end
    m_rr = 0; last_g = -1; last_data = 0;
    @(negedge clk);
    check_eq("rst_rsp_data", longint'($signed(rsp_data)), 0);
    check_eq("rst_rsp_valid2", longint'(rsp_valid), 0);
    drive();
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; r1_seen = 0;
    for (int i = 0; i < N; i++) begin
      v_valid[i] = 1'b0;
      v_ax[i] = 0; v_ay[i] = 0; v_bx[i] = 0; v_by[i] = 0; v_ox[i] = 0; v_oy[i] = 0;
    end
    reset = 1'b1;
    drive();
    @(negedge clk);
    do_reset();

    // Req0 only: positive result.
    set_op(0, 5, 0, 0, 5, 0, 0);
    drive(); #1;
    check_eq("t1_ready", longint'(req_ready), 1);
    step(); v_valid[0] = 1'b0;
    repeat (LAT - 1) step();
    #1;
    check_eq("t1_rsp_valid", longint'(rsp_valid), 1);
    check_eq("t1_rsp_data", longint'($signed(rsp_data)), 25);
    step();

    // Req1 only: negative result.
    set_op(1, 0, 5, 5, 0, 0, 0);
    step(); v_valid[1] = 1'b0;
    repeat (LAT - 1) step();
    #1;
    check_eq("t2_rsp_valid", longint'(rsp_valid), 2);
    check_eq("t2_rsp_data", longint'($signed(rsp_data)), -25);
    step();

    // Full-range extremes, both signs; second op also exercises the wrap search.
    set_op(0, 1023, -1024, -1024, 1023, -1024, -1024);
    step(); v_valid[0] = 1'b0;
    repeat (LAT - 1) step();
    #1;
    check_eq("t3_pos", longint'($signed(rsp_data)), 4190209);
    set_op(0, -1024, 1023, 1023, -1024, -1024, -1024);
    step(); v_valid[0] = 1'b0;
    repeat (LAT - 1) step();
    #1;
    check_eq("t3_neg", longint'($signed(rsp_data)), -4190209);
    step();

    // Both valid from reset: alternating grants, both inflight in steady state.
    do_reset();
    rand_op(0); rand_op(1);
    for (int k = 0; k < 6; k++) begin
      if (last_g >= 0) rand_op(last_g);
      drive(); #1;
      check_eq("t4_grant", longint'(req_ready), longint'(1 << (k % 2)));
      if (k >= LAT) check_eq("t4_inflight", longint'(inflight), 3);
      step();
    end
    v_valid[0] = 1'b0; v_valid[1] = 1'b0;
    repeat (LAT + 1) step();

    // Req1 pulsed for one cycle while rr=0 and req0 holds: req1 never served.
    do_reset();
    r1_seen = 0;
    rand_op(0); rand_op(1);
    drive(); #1;
    check_eq("t5_ready", longint'(req_ready), 1);
    step();
    v_valid[1] = 1'b0; rand_op(0);
    step();
    v_valid[0] = 1'b0;
    repeat (LAT + 2) step();
    check_eq("t5_r1_rsp", longint'(r1_seen), 0);

    // Reset with two ops in flight, then a clean op from req1.
    do_reset();
    rand_op(0); rand_op(1);
    step(); rand_op(0);
    step();
    do_reset();
    set_op(1, 3, 4, -2, 7, 1, 1);
    step(); v_valid[1] = 1'b0;
    repeat (LAT - 1) step();
    #1;
    check_eq("t6_rsp_valid", longint'(rsp_valid), 2);
    check_eq("t6_rsp_data", longint'($signed(rsp_data)), 21);
    step();

    // Random traffic: hold until granted or drop, issue new ops at random.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (v_valid[i] && last_g != i) begin
          if ($urandom_range(0, 4) == 0) v_valid[i] = 1'b0;
        end else begin
          v_valid[i] = 1'b0;
          if ($urandom_range(0, 2) != 0) rand_op(i);
        end
      end
      step();
    end
    for (int i = 0; i < N; i++) v_valid[i] = 1'b0;
    repeat (LAT + 2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
